// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-requester arbiter/sequencer for the decoded data bus.
// Define XBUS_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module xbus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int ACC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   output logic              bus_sel,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_data_to_rd,
   input  logic              bus_trap_sel,
   output logic              busy
);
   if (ACC_LAT < 1 || ACC_LAT > 15) begin : g_bad_lat
      $error("xbus_arbiter: ACC_LAT must be 1..15");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state;
   logic       gnt;
   logic [3:0] cnt;
   logic       pick;

`ifdef XBUS_ARB_RR_EN
   logic last_grant;
   // tie goes to whoever was not served last; a lone request always wins
   always_comb pick = (req0 && req1) ? ~last_grant : ~req0;
   // remember the most recent grantee, starting as 1 so requester 0 wins the first tie
   always_ff @(posedge clk)
      if (!rst_n) last_grant <= 1'b1;
      else if (state == IDLE && (req0 || req1)) last_grant <= pick;
`else
   // fixed priority: requester 1 only when requester 0 is idle
   always_comb pick = ~req0;
`endif

   // sequencer: grant and latch in IDLE, hold select for ACC_LAT cycles, then ack
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         cnt       <= 4'd0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         bus_sel   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               gnt       <= pick;
               bus_addr  <= pick ? addr1 : addr0;
               bus_we    <= pick ? we1 : we0;
               bus_wdata <= pick ? wdata1 : wdata0;
               cnt       <= 4'(ACC_LAT - 1);
               bus_sel   <= 1'b1;
               busy      <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               bus_we <= 1'b0;
               if (cnt == 4'd0) begin
                  bus_sel <= 1'b0;
                  state   <= DONE;
                  if (gnt) begin
                     rdata1 <= bus_data_to_rd;
                     err1   <= bus_trap_sel;
                     ack1   <= 1'b1;
                  end else begin
                     rdata0 <= bus_data_to_rd;
                     err0   <= bus_trap_sel;
                     ack0   <= 1'b1;
                  end
               end else cnt <= cnt - 4'd1;
            end
            DONE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed checks of xbus_arbiter at ACC_LAT=1 (u1) and ACC_LAT=3 (u3)
module tb_xbus_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic [31:0] bus_data_to_rd = '0;
   logic        bus_trap_sel = 1'b0;

   logic        a_ack0, a_err0, a_ack1, a_err1, a_sel, a_we, a_busy;
   logic [31:0] a_rdata0, a_rdata1, a_addr, a_wdata;
   logic        b_ack0, b_err0, b_ack1, b_err1, b_sel, b_we, b_busy;
   logic [31:0] b_rdata0, b_rdata1, b_addr, b_wdata;

   int checks = 0;
   int errors = 0;
   logic seen;

   xbus_arbiter #(.ACC_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(a_ack0), .err0(a_err0), .rdata0(a_rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(a_ack1), .err1(a_err1), .rdata1(a_rdata1),
      .bus_sel(a_sel), .bus_we(a_we), .bus_addr(a_addr), .bus_wdata(a_wdata),
      .bus_data_to_rd(bus_data_to_rd), .bus_trap_sel(bus_trap_sel), .busy(a_busy)
   );

   xbus_arbiter #(.ACC_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(b_ack0), .err0(b_err0), .rdata0(b_rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(b_ack1), .err1(b_err1), .rdata1(b_rdata1),
      .bus_sel(b_sel), .bus_we(b_we), .bus_addr(b_addr), .bus_wdata(b_wdata),
      .bus_data_to_rd(bus_data_to_rd), .bus_trap_sel(bus_trap_sel), .busy(b_busy)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // directed scenarios
   initial begin
      do_reset();
      chk("rst_sel", {31'b0, a_sel}, 32'd0);
      chk("rst_busy", {31'b0, a_busy}, 32'd0);
      chk("rst_ack", {30'b0, a_ack0, a_ack1}, 32'd0);
      chk("rst_rdata0", a_rdata0, 32'd0);
      chk("rst_addr", a_addr, 32'd0);

      // single read, ACC_LAT=1
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; bus_data_to_rd = 32'hDEADBEEF;
      tick();
      chk("rd_sel1", {31'b0, a_sel}, 32'd1);
      chk("rd_addr", a_addr, 32'h40);
      chk("rd_we", {31'b0, a_we}, 32'd0);
      chk("rd_ack_early", {31'b0, a_ack0}, 32'd0);
      tick();
      chk("rd_sel_off", {31'b0, a_sel}, 32'd0);
      chk("rd_ack0", {31'b0, a_ack0}, 32'd1);
      chk("rd_rdata0", a_rdata0, 32'hDEADBEEF);
      chk("rd_err0", {31'b0, a_err0}, 32'd0);
      chk("rd_ack1", {31'b0, a_ack1}, 32'd0);
      req0 = 1'b0;
      tick();
      chk("rd_ack_pulse", {31'b0, a_ack0}, 32'd0);
      chk("rd_rdata_hold", a_rdata0, 32'hDEADBEEF);

      // write from requester 1, ACC_LAT=3
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h5A5A5A5A; bus_data_to_rd = 32'h11112222;
      tick();
      chk("wr_sel_a", {31'b0, b_sel}, 32'd1);
      chk("wr_we_a", {31'b0, b_we}, 32'd1);
      chk("wr_addr", b_addr, 32'h10);
      chk("wr_wdata", b_wdata, 32'h5A5A5A5A);
      wdata1 = 32'h0;
      we1 = 1'b0;
      tick();
      chk("wr_sel_b", {31'b0, b_sel}, 32'd1);
      chk("wr_we_b", {31'b0, b_we}, 32'd0);
      chk("wr_wdata_hold", b_wdata, 32'h5A5A5A5A);
      tick();
      chk("wr_sel_c", {31'b0, b_sel}, 32'd1);
      chk("wr_we_c", {31'b0, b_we}, 32'd0);
      chk("wr_ack_early", {31'b0, b_ack1}, 32'd0);
      tick();
      chk("wr_ack1", {31'b0, b_ack1}, 32'd1);
      chk("wr_sel_off", {31'b0, b_sel}, 32'd0);
      chk("wr_rdata1", b_rdata1, 32'h11112222);
      chk("wr_rdata0_idle", b_rdata0, 32'd0);
      chk("wr_ack0", {31'b0, b_ack0}, 32'd0);
      req1 = 1'b0;
      tick();
      chk("wr_busy_off", {31'b0, b_busy}, 32'd0);

      // trap access, ACC_LAT=1
      do_reset();
      req0 = 1'b1; addr0 = 32'hFFFF0000; bus_data_to_rd = 32'h0; bus_trap_sel = 1'b1;
      tick();
      tick();
      chk("trap_ack0", {31'b0, a_ack0}, 32'd1);
      chk("trap_err0", {31'b0, a_err0}, 32'd1);
      chk("trap_err1", {31'b0, a_err1}, 32'd0);
      chk("trap_rdata0", a_rdata0, 32'd0);
      req0 = 1'b0; bus_trap_sel = 1'b0;
      tick();
      chk("trap_err_clr", {31'b0, a_err0}, 32'd0);

      // both held for four accesses, ACC_LAT=1
      do_reset();
      addr0 = 32'h100; addr1 = 32'h200; req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic exp_g;
`ifdef XBUS_ARB_RR_EN
         exp_g = (i % 2) == 1;
`else
         exp_g = 1'b0;
`endif
         tick();
         chk("tie_addr", a_addr, exp_g ? 32'h200 : 32'h100);
         tick();
         chk("tie_ack0", {31'b0, a_ack0}, {31'b0, ~exp_g});
         chk("tie_ack1", {31'b0, a_ack1}, {31'b0, exp_g});
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;

      // reset in the second ACCESS cycle aborts, ACC_LAT=3
      do_reset();
      req0 = 1'b1; addr0 = 32'h80;
      tick();
      tick();
      chk("abort_sel_pre", {31'b0, b_sel}, 32'd1);
      rst_n = 1'b0; req0 = 1'b0;
      tick();
      chk("abort_sel", {31'b0, b_sel}, 32'd0);
      chk("abort_busy", {31'b0, b_busy}, 32'd0);
      rst_n = 1'b1;
      seen = b_ack0 | b_ack1;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | b_ack0 | b_ack1;
      end
      chk("abort_no_ack", {31'b0, seen}, 32'd0);
      req0 = 1'b1; bus_data_to_rd = 32'hCAFEF00D;
      tick();
      chk("post_sel", {31'b0, b_sel}, 32'd1);
      tick();
      tick();
      tick();
      chk("post_ack0", {31'b0, b_ack0}, 32'd1);
      chk("post_rdata0", b_rdata0, 32'hCAFEF00D);
      req0 = 1'b0;

      // req0 dropped mid-access while requester 1 waits, ACC_LAT=3
      do_reset();
      req0 = 1'b1; addr0 = 32'h300; addr1 = 32'h400;
      tick();
      req0 = 1'b0; req1 = 1'b1;
      tick();
      tick();
      tick();
      chk("drop_ack0", {31'b0, b_ack0}, 32'd1);
      chk("drop_ack1", {31'b0, b_ack1}, 32'd0);
      tick();
      chk("drop_ack0_once", {31'b0, b_ack0}, 32'd0);
      chk("wait_sel_idle", {31'b0, b_sel}, 32'd0);
      tick();
      chk("wait_sel", {31'b0, b_sel}, 32'd1);
      chk("wait_addr", b_addr, 32'h400);
      tick();
      tick();
      tick();
      chk("wait_ack1", {31'b0, b_ack1}, 32'd1);
      req1 = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
